// File: rtl/lfsr_crypt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_crypt_pkg
// Description : Shared constants, FSM state type and pre_len clamp helper for
//               the 6-bit LFSR encryption sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_crypt_pkg;

    localparam int DW        = 8;
    localparam int AW        = 8;
    localparam int LW        = 6;
    localparam int IW        = 7;
    localparam int FRAME_LEN = 64;

    localparam logic [AW-1:0] CFG_BASE = 8'd61;
    localparam logic [AW-1:0] MSG_BASE = 8'd0;
    localparam logic [AW-1:0] DST_BASE = 8'd64;
    localparam logic [DW-1:0] PAD      = 8'h5F;
    localparam logic [DW-1:0] PRE_MIN  = 8'd7;
    localparam logic [DW-1:0] PRE_MAX  = 8'd12;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LD_PRE  = 4'd1,
        S_LD_TAPS = 4'd2,
        S_LD_SEED = 4'd3,
        S_CHK     = 4'd4,
        S_LD_LFSR = 4'd5,
        S_PRE     = 4'd6,
        S_MSG     = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    // Bound a raw preamble length into the supported window
    function automatic logic [DW-1:0] clamp_pre(input logic [DW-1:0] v);
        if (v < PRE_MIN)      return PRE_MIN;
        else if (v > PRE_MAX) return PRE_MAX;
        else                  return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_cfg_regs
// Description : Captures pre_len (clamped), taps and seed from dat_mem and
//               flags an unusable configuration (all-zero taps or seed).
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_cfg_regs
    import lfsr_crypt_pkg::*;
(
    input  logic          clk,
    input  logic          init_n,
    input  logic          cap_pre,
    input  logic          cap_taps,
    input  logic          cap_seed,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] pre_len,
    output logic [LW-1:0] taps,
    output logic [LW-1:0] seed,
    output logic          cfg_bad
);

    logic [DW-1:0] r_pre_len;
    logic [LW-1:0] r_taps;
    logic [LW-1:0] r_seed;

    // Load each config field in its own read slot; every run recaptures all three
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_pre_len <= '0;
            r_taps    <= '0;
            r_seed    <= '0;
        end else begin
            if (cap_pre)  r_pre_len <= clamp_pre(rd_data);
            if (cap_taps) r_taps    <= rd_data[LW-1:0];
            if (cap_seed) r_seed    <= rd_data[LW-1:0];
        end
    end

    assign pre_len = r_pre_len;
    assign taps    = r_taps;
    assign seed    = r_seed;
    // An all-zero tap set or seed would lock the LFSR, so the run is refused
    assign cfg_bad = (r_taps == '0) || (r_seed == '0);

endmodule
`default_nettype wire

// File: rtl/lfsr_crypt_seq.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_crypt_seq
// Description : FSM sequencer for the 6-bit LFSR encryption datapath. Reads
//               config, loads the LFSR, writes a PAD preamble and then the
//               encrypted message into the destination frame.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_crypt_seq
    import lfsr_crypt_pkg::*;
(
    input  logic          clk,
    input  logic          init_n,
    input  logic          go,
    input  logic [DW-1:0] rd_data,
    input  logic [LW-1:0] lfsr_state,
    output logic [AW-1:0] raddr,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wr_data,
    output logic          write_en,
    output logic          lfsr_en,
    output logic          load_lfsr,
    output logic [LW-1:0] taps,
    output logic [LW-1:0] seed,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic          r_err;
    logic          r_armed;

    logic [DW-1:0] w_pre_len;
    logic          w_cfg_bad;
    logic          w_go_ok;
    logic          w_pre_last;
    logic          w_frame_last;
    logic [AW-1:0] w_idx_ext;
    logic [AW-1:0] w_msg_k;
    logic [DW-1:0] w_lfsr_ext;

    lfsr_cfg_regs u_cfg (
        .clk      (clk),
        .init_n   (init_n),
        .cap_pre  (r_state == S_LD_PRE),
        .cap_taps (r_state == S_LD_TAPS),
        .cap_seed (r_state == S_LD_SEED),
        .rd_data  (rd_data),
        .pre_len  (w_pre_len),
        .taps     (taps),
        .seed     (seed),
        .cfg_bad  (w_cfg_bad)
    );

    // r_armed stays low through the first edge after reset release, so a go
    // coinciding with that edge is not taken as a start
    assign w_go_ok      = go && r_armed;
    assign w_idx_ext    = {{(AW-IW){1'b0}}, r_idx};
    assign w_pre_last   = (w_idx_ext == (w_pre_len - 8'd1));
    assign w_frame_last = (r_idx == IW'(FRAME_LEN - 1));
    assign w_msg_k      = w_idx_ext - w_pre_len;
    assign w_lfsr_ext   = {{(DW-LW){1'b0}}, lfsr_state};

    // Run sequencing, write index and sticky error flag
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go_ok) begin
                        r_state <= S_LD_PRE;
                        r_idx   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_LD_PRE:  r_state <= S_LD_TAPS;
                S_LD_TAPS: r_state <= S_LD_SEED;
                S_LD_SEED: r_state <= S_CHK;
                S_CHK: begin
                    if (w_cfg_bad) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_LD_LFSR;
                    end
                end
                S_LD_LFSR: r_state <= S_PRE;
                S_PRE: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_pre_last) r_state <= S_MSG;
                end
                S_MSG: begin
                    if (w_frame_last) r_state <= S_DONE;
                    else              r_idx   <= r_idx + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Moore decode of the memory/LFSR control pins; only MSG data passes rd_data through
    always_comb begin
        raddr     = '0;
        waddr     = '0;
        wr_data   = '0;
        write_en  = 1'b0;
        lfsr_en   = 1'b0;
        load_lfsr = 1'b0;
        case (r_state)
            S_LD_PRE:  raddr = CFG_BASE;
            S_LD_TAPS: raddr = CFG_BASE + 8'd1;
            S_LD_SEED: raddr = CFG_BASE + 8'd2;
            S_LD_LFSR: load_lfsr = 1'b1;
            S_PRE: begin
                waddr    = DST_BASE + w_idx_ext;
                wr_data  = PAD ^ w_lfsr_ext;
                write_en = 1'b1;
                lfsr_en  = 1'b1;
            end
            S_MSG: begin
                raddr    = MSG_BASE + w_msg_k;
                waddr    = DST_BASE + w_idx_ext;
                wr_data  = rd_data ^ w_lfsr_ext;
                write_en = 1'b1;
                lfsr_en  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done = (r_state == S_DONE);
    assign err  = r_err;

endmodule
`default_nettype wire
